// File: rtl/fight_pkg.sv
// Shared state and option codes, the skill damage table and the LFSR seed
// for the fight screen sequencer.
package fight_pkg;

  typedef enum logic [5:0] {
    ST_MENU     = 6'd1,
    ST_CHOOSE   = 6'd2,
    ST_ANIM_P1  = 6'd3,
    ST_ANIM_P2  = 6'd4,
    ST_HPRED_P1 = 6'd5,
    ST_HPRED_P2 = 6'd6,
    ST_OVER     = 6'd7
  } fight_state_e;

  typedef enum logic [3:0] {
    OPT_TL = 4'd1,
    OPT_TR = 4'd2,
    OPT_BL = 4'd3,
    OPT_BR = 4'd4
  } option_e;

  typedef enum logic [2:0] {
    MV_NONE,
    MV_UP,
    MV_DOWN,
    MV_LEFT,
    MV_RIGHT
  } move_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic logic [7:0] skill_dmg(input logic [3:0] skill);
    logic [7:0] dmg;
    case (skill)
      4'd2:    dmg = 8'd20;
      4'd3:    dmg = 8'd30;
      4'd4:    dmg = 8'd40;
      default: dmg = 8'd10;
    endcase
    return dmg;
  endfunction

  // 2x2 grid navigation; moves off the edge leave the highlight where it is
  function automatic option_e move_option(input option_e opt, input move_e mv);
    option_e nxt;
    nxt = opt;
    case (mv)
      MV_LEFT: begin
        if (opt == OPT_TR) nxt = OPT_TL;
        else if (opt == OPT_BR) nxt = OPT_BL;
      end
      MV_RIGHT: begin
        if (opt == OPT_TL) nxt = OPT_TR;
        else if (opt == OPT_BL) nxt = OPT_BR;
      end
      MV_UP: begin
        if (opt == OPT_BL) nxt = OPT_TL;
        else if (opt == OPT_BR) nxt = OPT_TR;
      end
      MV_DOWN: begin
        if (opt == OPT_TL) nxt = OPT_BL;
        else if (opt == OPT_TR) nxt = OPT_BR;
      end
      default: nxt = opt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/hp_drain.sv
// Paces an HP bar drain: one decrement every TICK_DIV cycles while active,
// tracking the damage still owed and flagging the tick that finishes it.
module hp_drain
  #(parameter int TICK_DIV = 2500000)
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       start,
    input  logic       active,
    input  logic [7:0] damage,
    input  logic [7:0] cur_hp,
    output logic       dec,
    output logic       done
  );

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic [7:0]    pending;
  logic          tick;

  assign tick = active && (tick_cnt == TICK_LAST);
  assign dec  = tick && (cur_hp != 8'd0) && (pending != 8'd0);
  // finishing tick: either the owed damage or the HP itself runs out here
  assign done = tick && ((pending <= 8'd1) || (cur_hp <= 8'd1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick_cnt <= '0;
      pending  <= 8'd0;
    end else begin
      if (start)
        pending <= damage;
      else if (dec)
        pending <= pending - 8'd1;

      if (!active || tick)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fight_controller.sv
// Fight screen sequencer: menu, skill choice, attack animations and HP drains.
// Define FIGHT_P2_RANDOM_EN to pick P2's skill from an 8-bit LFSR instead of always skill 1.
module fight_controller
  import fight_pkg::*;
  #(
    parameter int HP_MAX      = 200,
    parameter int TICK_DIV    = 2500000,
    parameter int ANIM_CYCLES = 50000000
  )
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_enter,
    output logic [5:0] fight_state,
    output logic [3:0] option_state,
    output logic [7:0] p1_cur_hp,
    output logic [7:0] p2_cur_hp,
    output logic       game_over,
    output logic [1:0] winner
  );

  localparam int AW = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_CYCLES - 1);
  localparam logic [7:0]    HP_START  = 8'(HP_MAX);

  fight_state_e  state;
  option_e       option;
  logic [7:0]    p1_hp;
  logic [7:0]    p2_hp;
  logic [AW-1:0] anim_cnt;
  logic          anim_active;
  logic          anim_done;
  logic          restart;
  move_e         mv;

  logic          drain_active;
  logic          drain_start;
  logic          drain_dec;
  logic          drain_done;
  logic [7:0]    drain_dmg;
  logic [7:0]    drain_hp;

  assign anim_active  = (state == ST_ANIM_P1) || (state == ST_ANIM_P2);
  assign anim_done    = anim_active && (anim_cnt == ANIM_LAST);
  assign restart      = (state == ST_OVER) && key_enter;
  assign drain_active = (state == ST_HPRED_P1) || (state == ST_HPRED_P2);
  assign drain_hp     = (state == ST_HPRED_P1) ? p1_hp : p2_hp;

`ifdef FIGHT_P2_RANDOM_EN
  logic [7:0] lfsr;
  logic [3:0] p2_skill;

  // free-running x^8+x^6+x^5+x^4+1 sequence; P2's pick is frozen as ANIM_P1 ends
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      p2_skill <= 4'd1;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if ((state == ST_ANIM_P1) && anim_done)
        p2_skill <= {2'b00, lfsr[1:0]} + 4'd1;
    end
  end
`else
  logic [3:0] p2_skill;
  assign p2_skill = 4'd1;
`endif

  always_comb begin
    mv = MV_NONE;
    if (key_up)         mv = MV_UP;
    else if (key_down)  mv = MV_DOWN;
    else if (key_left)  mv = MV_LEFT;
    else if (key_right) mv = MV_RIGHT;
  end

  // the single drain engine is loaded with P2's damage on skill confirm and with P1's damage as P2's drain ends
  always_comb begin
    drain_start = 1'b0;
    drain_dmg   = skill_dmg(p2_skill);
    if ((state == ST_CHOOSE) && key_enter) begin
      drain_start = 1'b1;
      drain_dmg   = skill_dmg(option);
    end else if ((state == ST_HPRED_P2) && drain_done) begin
      drain_start = 1'b1;
    end
  end

  hp_drain #(.TICK_DIV(TICK_DIV)) u_hp_drain (
    .clk    (clk),
    .rst    (rst),
    .clear  (restart),
    .start  (drain_start),
    .active (drain_active),
    .damage (drain_dmg),
    .cur_hp (drain_hp),
    .dec    (drain_dec),
    .done   (drain_done)
  );

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state     <= ST_MENU;
      option    <= OPT_TL;
      p1_hp     <= HP_START;
      p2_hp     <= HP_START;
      game_over <= 1'b0;
      winner    <= 2'd0;
      anim_cnt  <= '0;
    end else begin
      if (anim_active && !anim_done)
        anim_cnt <= anim_cnt + 1'b1;
      else
        anim_cnt <= '0;

      case (state)
        ST_MENU: begin
          if (key_enter) begin
            if (option == OPT_TL) state <= ST_CHOOSE;
          end else begin
            option <= move_option(option, mv);
          end
        end
        ST_CHOOSE: begin
          if (key_enter)
            state <= ST_ANIM_P1;
          else
            option <= move_option(option, mv);
        end
        ST_ANIM_P1: if (anim_done) state <= ST_HPRED_P2;
        ST_ANIM_P2: if (anim_done) state <= ST_HPRED_P1;
        ST_HPRED_P2: begin
          if (drain_dec) p2_hp <= p2_hp - 8'd1;
          if (drain_done) begin
            if (p2_hp <= 8'd1) begin
              state     <= ST_OVER;
              winner    <= 2'd1;
              game_over <= 1'b1;
            end else begin
              state <= ST_ANIM_P2;
            end
          end
        end
        ST_HPRED_P1: begin
          if (drain_dec) p1_hp <= p1_hp - 8'd1;
          if (drain_done) begin
            if (p1_hp <= 8'd1) begin
              state     <= ST_OVER;
              winner    <= 2'd2;
              game_over <= 1'b1;
            end else begin
              state  <= ST_MENU;
              option <= OPT_TL;
            end
          end
        end
        ST_OVER: state <= ST_OVER;
        default: state <= ST_MENU;
      endcase
    end
  end

  assign fight_state  = state;
  assign option_state = option;
  assign p1_cur_hp    = p1_hp;
  assign p2_cur_hp    = p2_hp;

endmodule

// File: tb/tb_fight_controller.sv
// Scoreboard bench for fight_controller: the driver runs a behavioural model and queues
// the expected outputs for each cycle; a monitor pops and compares after every clock edge.
module tb_fight_controller;

  localparam int HP_MAX      = 200;
  localparam int TICK_DIV    = 4;
  localparam int ANIM_CYCLES = 8;

  localparam logic [4:0] K_ENTER = 5'b10000;
  localparam logic [4:0] K_UP    = 5'b01000;
  localparam logic [4:0] K_DOWN  = 5'b00100;
  localparam logic [4:0] K_LEFT  = 5'b00010;
  localparam logic [4:0] K_RIGHT = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_enter = 1'b0;
  logic [5:0] fight_state;
  logic [3:0] option_state;
  logic [7:0] p1_cur_hp;
  logic [7:0] p2_cur_hp;
  logic       game_over;
  logic [1:0] winner;

  fight_controller #(
    .HP_MAX      (HP_MAX),
    .TICK_DIV    (TICK_DIV),
    .ANIM_CYCLES (ANIM_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_enter    (key_enter),
    .fight_state  (fight_state),
    .option_state (option_state),
    .p1_cur_hp    (p1_cur_hp),
    .p2_cur_hp    (p2_cur_hp),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] st;
    logic [3:0] opt;
    logic [7:0] p1;
    logic [7:0] p2;
    logic       over;
    logic [1:0] win;
  } snap_t;

  snap_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  // model: phase 1..7, timers count remaining cycles until the next event
  int m_state = 1, m_opt = 1, m_p1 = HP_MAX, m_p2 = HP_MAX, m_over = 0, m_win = 0;
  int m_timer = 0, m_pending = 0, m_p2_skill = 1, m_lfsr = 'hA5;

  task automatic modelStep(input bit r, input logic [4:0] k);
    int row, col, smp;
    smp = m_p2_skill;
`ifdef FIGHT_P2_RANDOM_EN
    smp = (m_lfsr & 3) + 1;
`endif
    if (r || (m_state == 7 && k[4])) begin
      m_state = 1; m_opt = 1; m_p1 = HP_MAX; m_p2 = HP_MAX; m_over = 0; m_win = 0;
      if (r) m_p2_skill = 1;
    end else begin
      case (m_state)
        1, 2: begin
          row = (m_opt - 1) / 2;
          col = (m_opt - 1) % 2;
          if (k[4]) begin
            if (m_state == 1) begin
              if (m_opt == 1) m_state = 2;
            end else begin
              m_pending = 10 * m_opt;
              m_state   = 3;
              m_timer   = ANIM_CYCLES;
            end
          end else begin
            if (k[3])      row = 0;
            else if (k[2]) row = 1;
            else if (k[1]) col = 0;
            else if (k[0]) col = 1;
            m_opt = row * 2 + col + 1;
          end
        end
        3, 4: begin
          m_timer--;
          if (m_timer == 0) begin
            if (m_state == 3) m_p2_skill = smp;
            m_state = (m_state == 3) ? 6 : 5;
            m_timer = TICK_DIV;
          end
        end
        5, 6: begin
          m_timer--;
          if (m_timer == 0) begin
            m_timer = TICK_DIV;
            m_pending--;
            if (m_state == 6) m_p2 = (m_p2 > 0) ? m_p2 - 1 : 0;
            else              m_p1 = (m_p1 > 0) ? m_p1 - 1 : 0;
            if (m_state == 6 && (m_p2 == 0 || m_pending == 0)) begin
              if (m_p2 == 0) begin m_state = 7; m_win = 1; m_over = 1; end
              else begin m_state = 4; m_timer = ANIM_CYCLES; m_pending = 10 * m_p2_skill; end
            end else if (m_state == 5 && (m_p1 == 0 || m_pending == 0)) begin
              if (m_p1 == 0) begin m_state = 7; m_win = 2; m_over = 1; end
              else begin m_state = 1; m_opt = 1; end
            end
          end
        end
        default: ;
      endcase
    end
    if (r) m_lfsr = 'hA5;
    else   m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 'hFF;
  endtask

  task automatic applyStimulus(input bit r, input logic [4:0] k);
    snap_t s;
    @(negedge clk);
    rst       = r;
    key_enter = k[4];
    key_up    = k[3];
    key_down  = k[2];
    key_left  = k[1];
    key_right = k[0];
    modelStep(r, k);
    s.st   = 6'(m_state);
    s.opt  = 4'(m_opt);
    s.p1   = 8'(m_p1);
    s.p2   = 8'(m_p2);
    s.over = 1'(m_over);
    s.win  = 2'(m_win);
    exp_q.push_back(s);
  endtask

  task automatic checkOutput(input snap_t e);
    snap_t got;
    got = {fight_state, option_state, p1_cur_hp, p2_cur_hp, game_over, winner};
    checks++;
    if (got !== e) begin
      failures++;
      $display("[TB] FAIL outputs t=%0t got st=%0d opt=%0d p1=%0d p2=%0d over=%0d win=%0d expected st=%0d opt=%0d p1=%0d p2=%0d over=%0d win=%0d",
               $time, got.st, got.opt, got.p1, got.p2, got.over, got.win,
               e.st, e.opt, e.p1, e.p2, e.over, e.win);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'b0);
  endtask

  task automatic runUntil(input int a, input int b, input int budget);
    int n = 0;
    while (m_state != a && m_state != b && n < budget) begin
      applyStimulus(1'b0, 5'b0);
      n++;
    end
    if (m_state != a && m_state != b) begin
      failures++;
      $display("[TB] FAIL wait_state timeout got model state %0d expected %0d or %0d", m_state, a, b);
    end
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : driver
    logic [4:0] k;
    bit         r;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'b0);
    idle(2);

    applyStimulus(1'b0, K_RIGHT);
    applyStimulus(1'b0, K_ENTER);
    applyStimulus(1'b0, K_LEFT);
    applyStimulus(1'b0, K_ENTER);
    applyStimulus(1'b0, K_RIGHT);
    applyStimulus(1'b0, K_DOWN);
    applyStimulus(1'b0, K_LEFT);
    applyStimulus(1'b0, K_UP);
    applyStimulus(1'b0, K_UP);
    applyStimulus(1'b0, K_LEFT);
    applyStimulus(1'b0, K_UP | K_ENTER);
    idle(3);
    applyStimulus(1'b0, 5'b11111);
    applyStimulus(1'b0, K_RIGHT | K_DOWN);
    runUntil(1, 1, 1000);

    for (int round = 0; round < 5; round++) begin
      applyStimulus(1'b0, K_ENTER);
      applyStimulus(1'b0, K_RIGHT);
      applyStimulus(1'b0, K_DOWN);
      applyStimulus(1'b0, K_ENTER);
      runUntil(1, 7, 2000);
    end
    applyStimulus(1'b0, 5'b01111);
    applyStimulus(1'b0, K_UP);
    applyStimulus(1'b0, K_LEFT);
    idle(2);
    applyStimulus(1'b0, K_ENTER);
    idle(2);

    applyStimulus(1'b0, K_ENTER);
    applyStimulus(1'b0, K_ENTER);
    idle(ANIM_CYCLES + 6);
    applyStimulus(1'b1, 5'b0);
    idle(3);

    for (int i = 0; i < 15000; i++) begin
      k = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
      r = ($urandom_range(0, 4999) == 0);
      applyStimulus(r, k);
    end

    idle(2);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL queue_drain got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
